// File: rtl/subtractor_pkg.sv
// Shared definitions for the pipelined subtractor: default widths and depth,
// output-width helper and the bit layout of the record carried by each stage.
package subtractor_pkg;

  localparam int DEFAULT_DATA_WIDTH_1 = 16;
  localparam int DEFAULT_DATA_WIDTH_2 = 16;
  localparam int DEFAULT_PIPE_STAGES  = 2;

  // Stage record layout: {borrow, data}, data starting at bit 0.
  localparam int DATA_LSB = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Borrow sits immediately above the data field.
  function automatic int borrow_bit(input int out_width);
    return DATA_LSB + out_width;
  endfunction

  function automatic int payload_width(input int out_width);
    return out_width + 1;
  endfunction

endpackage

// File: rtl/subtractor_pipe_stage.sv
// pipe_stage: one valid/ready register stage holding {valid, payload}.
// The stage loads when it is empty or its current contents leave this cycle,
// so a full chain of these moves as one without inserting bubbles.
module pipe_stage #(
  parameter int PAYLOAD_WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);

  logic                     valid;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic                     load;

  assign load = !valid || out_ready;

  // Stage register: capture new contents when free; payload only changes on a
  // real load so a stalled output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        payload <= in_payload;
      end
    end
  end

  assign out_valid   = valid;
  assign out_payload = payload;

endmodule

// File: rtl/subtractor.sv
// subtractor: pipelined unsigned subtractor with valid/ready handshake.
// data_o = data1_i - data2_i on operands zero-extended to OUT_WIDTH, plus a
// borrow flag. Build option SUBTRACTOR_SATURATE_EN clamps borrowing results
// to zero while still reporting borrow_o = 1.
module subtractor
  import subtractor_pkg::*;
#(
  parameter  int DATA_WIDTH_1 = DEFAULT_DATA_WIDTH_1,
  parameter  int DATA_WIDTH_2 = DEFAULT_DATA_WIDTH_2,
  parameter  int PIPE_STAGES  = DEFAULT_PIPE_STAGES,
  localparam int OUT_WIDTH    = max_int(DATA_WIDTH_1, DATA_WIDTH_2) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH_1-1:0] data1_i,
  input  logic [DATA_WIDTH_2-1:0] data2_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [OUT_WIDTH-1:0]    data_o,
  output logic                    borrow_o
);

  localparam int PAYLOAD_WIDTH = payload_width(OUT_WIDTH);
  localparam int BORROW_BIT    = borrow_bit(OUT_WIDTH);

  logic [OUT_WIDTH-1:0]     minuend;
  logic [OUT_WIDTH-1:0]     subtrahend;
  logic [OUT_WIDTH-1:0]     diff;
  logic [OUT_WIDTH-1:0]     result;
  logic                     borrow;
  logic [PAYLOAD_WIDTH-1:0] in_payload;

  // Stage outputs: occupancy and payload of every register stage.
  logic [PIPE_STAGES-1:0]   occ;
  logic [PAYLOAD_WIDTH-1:0] stage_payload [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]   stage_out_ready;
  logic                     ready_acc;

  // One extra bit of headroom makes the difference exact; its MSB is the borrow.
  assign minuend    = OUT_WIDTH'(data1_i);
  assign subtrahend = OUT_WIDTH'(data2_i);
  assign diff       = minuend - subtrahend;
  assign borrow     = diff[OUT_WIDTH-1];

  // Value carried down the pipe: full difference, or clamped on underflow.
  always_comb begin
    result = diff;
`ifdef SUBTRACTOR_SATURATE_EN
    if (borrow) begin
      result = '0;
    end
`endif
  end

  assign in_payload = {borrow, result};

  // Ready for stage k is true when the consumer takes data or any stage from
  // k to the output is empty; computed from occupancy so no ready loop exists.
  always_comb begin
    stage_out_ready = '0;
    ready_acc       = ready_i;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      stage_out_ready[k] = ready_acc;
      ready_acc          = ready_acc | ~occ[k];
    end
    ready_o = ready_acc;
  end

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    logic                     in_valid_s;
    logic [PAYLOAD_WIDTH-1:0] in_payload_s;

    if (gi == 0) begin : g_first
      assign in_valid_s   = valid_i;
      assign in_payload_s = in_payload;
    end else begin : g_rest
      assign in_valid_s   = occ[gi-1];
      assign in_payload_s = stage_payload[gi-1];
    end

    pipe_stage #(
      .PAYLOAD_WIDTH(PAYLOAD_WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid_s),
      .in_payload (in_payload_s),
      .out_ready  (stage_out_ready[gi]),
      .out_valid  (occ[gi]),
      .out_payload(stage_payload[gi])
    );
  end

  assign valid_o  = occ[PIPE_STAGES-1];
  assign data_o   = stage_payload[PIPE_STAGES-1][DATA_LSB +: OUT_WIDTH];
  assign borrow_o = stage_payload[PIPE_STAGES-1][BORROW_BIT];

endmodule
